// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: four 8-bit masters share one slave port.
// The winning master's cycle is registered onto the slave bus; the ack or a
// timeout error is returned to that master one cycle later. Every output
// comes straight from a flop, so there is no combinational input-to-output path.
module wb_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [3:0]  m_stb_i,
    input  logic [3:0]  m_we_i,
    input  logic [31:0] m_addr_i,
    input  logic [31:0] m_data_i,
    output logic [7:0]  m_data_o,
    output logic [3:0]  m_ack_o,
    output logic [3:0]  m_err_o,
    output logic [7:0]  s_addr_o,
    output logic [7:0]  s_data_o,
    input  logic [7:0]  s_data_i,
    output logic        s_stb_o,
    output logic        s_we_o,
    input  logic        s_ack_i,
    output logic [1:0]  grant_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    // Counter value seen in the last ACCESS cycle before the abort.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q,  state_d;
    logic [7:0]  s_addr_q, s_addr_d;
    logic [7:0]  s_data_q, s_data_d;
    logic        s_we_q,   s_we_d;
    logic        s_stb_q,  s_stb_d;
    logic [7:0]  m_data_q, m_data_d;
    logic [3:0]  m_ack_q,  m_ack_d;
    logic [3:0]  m_err_q,  m_err_d;
    logic [1:0]  grant_q,  grant_d;
    logic [1:0]  last_q,   last_d;
    logic [7:0]  cnt_q,    cnt_d;
    logic        busy_q,   busy_d;
    logic [1:0]  win_s;

    // Round-robin pick: search last+1, last+2, last+3, last (mod 4).
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] req);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + i[1:0];
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    assign win_s = rr_pick(last_q, m_stb_i);

    // Next-state and registered-output computation for the three-state FSM.
    always_comb begin
        state_d  = state_q;
        s_addr_d = s_addr_q;
        s_data_d = s_data_q;
        s_we_d   = s_we_q;
        s_stb_d  = s_stb_q;
        m_data_d = m_data_q;
        m_ack_d  = 4'b0000;
        m_err_d  = 4'b0000;
        grant_d  = grant_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (|m_stb_i) begin
                    s_addr_d = m_addr_i[{win_s, 3'b000} +: 8];
                    s_data_d = m_data_i[{win_s, 3'b000} +: 8];
                    s_we_d   = m_we_i[win_s];
                    grant_d  = win_s;
                    last_d   = win_s;
                    cnt_d    = 8'd0;
                    s_stb_d  = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = ST_ACCESS;
                end else begin
                    s_stb_d  = 1'b0;
                    busy_d   = 1'b0;
                end
            end
            ST_ACCESS: begin
                if (s_ack_i) begin
                    // An ack on the timeout cycle still counts as a completion.
                    if (!s_we_q) begin
                        m_data_d = s_data_i;
                    end else begin
                        m_data_d = m_data_q;
                    end
                    m_ack_d = 4'b0001 << grant_q;
                    s_stb_d = 1'b0;
                    state_d = ST_RELEASE;
                end else if (cnt_q == TO_LAST) begin
                    m_err_d = 4'b0001 << grant_q;
                    s_stb_d = 1'b0;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                end
            end
            ST_RELEASE: begin
                s_stb_d = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                s_stb_d = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears strobe/ack/err immediately.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q  <= ST_IDLE;
            s_addr_q <= 8'd0;
            s_data_q <= 8'd0;
            s_we_q   <= 1'b0;
            s_stb_q  <= 1'b0;
            m_data_q <= 8'd0;
            m_ack_q  <= 4'b0000;
            m_err_q  <= 4'b0000;
            grant_q  <= 2'd0;
            last_q   <= 2'd3;
            cnt_q    <= 8'd0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_addr_q <= s_addr_d;
            s_data_q <= s_data_d;
            s_we_q   <= s_we_d;
            s_stb_q  <= s_stb_d;
            m_data_q <= m_data_d;
            m_ack_q  <= m_ack_d;
            m_err_q  <= m_err_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign s_addr_o = s_addr_q;
    assign s_data_o = s_data_q;
    assign s_we_o   = s_we_q;
    assign s_stb_o  = s_stb_q;
    assign m_data_o = m_data_q;
    assign m_ack_o  = m_ack_q;
    assign m_err_o  = m_err_q;
    assign grant_o  = grant_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model (round-robin pick, latency, memory image).
module tb_wb_arbiter;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  m_stb_i, m_we_i;
    logic [31:0] m_addr_i, m_data_i;
    logic [7:0]  m_data_o;
    logic [3:0]  m_ack_o, m_err_o;
    logic [7:0]  s_addr_o, s_data_o, s_data_i;
    logic        s_stb_o, s_we_o, s_ack_i;
    logic [1:0]  grant_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Slave model state.
    logic [7:0] mem [256];
    int         wait_target = 0;
    bit         ack_en      = 1'b1;
    bit         mem_init    = 1'b1;
    int         acc_cnt     = 0;

    // Reference model state.
    logic [7:0] ref_mem [256];
    int         last_m   = 3;
    logic [7:0] exp_data = 8'h00;

    always #5 clk = ~clk;

    wb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .m_stb_i  (m_stb_i),
        .m_we_i   (m_we_i),
        .m_addr_i (m_addr_i),
        .m_data_i (m_data_i),
        .m_data_o (m_data_o),
        .m_ack_o  (m_ack_o),
        .m_err_o  (m_err_o),
        .s_addr_o (s_addr_o),
        .s_data_o (s_data_o),
        .s_data_i (s_data_i),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_ack_i  (s_ack_i),
        .grant_o  (grant_o),
        .busy_o   (busy_o)
    );

    function automatic logic [7:0] seed_byte(input int i);
        return 8'(i * 37 + 11);
    endfunction

    // Slave: acks after wait_target strobe cycles, combinationally from s_stb_o.
    assign s_ack_i  = s_stb_o && ack_en && (acc_cnt == wait_target);
    assign s_data_i = mem[s_addr_o];

    // Slave memory, wait counter and cycle counter.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        acc_cnt <= s_stb_o ? acc_cnt + 1 : 0;
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= seed_byte(i);
        end else if (s_stb_o && s_ack_i && s_we_o) begin
            mem[s_addr_o] <= s_data_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Round-robin as stated: first requester among last+1 .. last+4 (mod 4).
    function automatic int rr_model(input int last, input logic [3:0] req);
        for (int i = 1; i <= 4; i++) begin
            if (req[(last + i) % 4]) return (last + i) % 4;
        end
        return 0;
    endfunction

    // One arbitrated transaction, starting at the IDLE-cycle negedge.
    task automatic txn(input int waits, input bit ack_on, input bit keep, input logic [3:0] late_mask);
        int         w, n, t0, exp_n;
        bit         acked, we;
        logic [7:0] a, d;
        w  = rr_model(last_m, m_stb_i);
        a  = m_addr_i[8*w +: 8];
        d  = m_data_i[8*w +: 8];
        we = m_we_i[w];
        wait_target = waits;
        ack_en      = ack_on;
        acked = ack_on && (waits <= TO - 1);
        exp_n = acked ? waits + 1 : TO;
        t0 = cyc;
        @(negedge clk);
        check("stb_start", 32'(s_stb_o), 32'd1);
        check("grant", 32'(grant_o), 32'(w));
        check("s_addr", 32'(s_addr_o), 32'(a));
        check("s_we", 32'(s_we_o), 32'(we));
        if (we) check("s_data", 32'(s_data_o), 32'(d));
        check("busy_access", 32'(busy_o), 32'd1);
        m_stb_i = m_stb_i | late_mask;
        n = 0;
        while (s_stb_o === 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
        check("stb_cycles", 32'(n), 32'(exp_n));
        check("ack", 32'(m_ack_o), acked ? 32'(4'b0001 << w) : 32'd0);
        check("err", 32'(m_err_o), acked ? 32'd0 : 32'(4'b0001 << w));
        if (acked && !we) exp_data = ref_mem[a];
        if (acked && we)  ref_mem[a] = d;
        check("m_data", 32'(m_data_o), 32'(exp_data));
        check("busy_release", 32'(busy_o), 32'd1);
        last_m = w;
        if (!keep) m_stb_i[w] = 1'b0;
        @(negedge clk);
        check("ack_idle", 32'(m_ack_o), 32'd0);
        check("err_idle", 32'(m_err_o), 32'd0);
        check("busy_idle", 32'(busy_o), 32'd0);
        check("txn_cycles", 32'(cyc - t0), 32'(exp_n + 2));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_stb"},   32'(s_stb_o),  32'd0);
        check({tag, "_ack"},   32'(m_ack_o),  32'd0);
        check({tag, "_err"},   32'(m_err_o),  32'd0);
        check({tag, "_busy"},  32'(busy_o),   32'd0);
        check({tag, "_grant"}, 32'(grant_o),  32'd0);
        check({tag, "_addr"},  32'(s_addr_o), 32'd0);
        check({tag, "_wdat"},  32'(s_data_o), 32'd0);
        check({tag, "_we"},    32'(s_we_o),   32'd0);
        check({tag, "_rdat"},  32'(m_data_o), 32'd0);
    endtask

    // Directed and randomized stimulus sequence.
    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = seed_byte(i);
        rst_n = 1'b0;
        m_stb_i = 4'b0000; m_we_i = 4'b0000;
        m_addr_i = 32'd0;  m_data_i = 32'd0;
        @(negedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);
        mem_init = 1'b0;
        @(negedge clk);

        // Master 1 writes A5 to 0x10, then reads it back.
        m_addr_i[15:8] = 8'h10; m_data_i[15:8] = 8'hA5; m_we_i[1] = 1'b1;
        m_stb_i = 4'b0010;
        txn(0, 1'b1, 1'b0, 4'b0000);
        m_we_i[1] = 1'b0; m_stb_i = 4'b0010;
        txn(0, 1'b1, 1'b0, 4'b0000);
        check("readback_a5", 32'(m_data_o), 32'h0000_00A5);

        // Timeout: slave never acks, master 2 reads.
        m_addr_i[23:16] = 8'h33; m_we_i[2] = 1'b0; m_stb_i = 4'b0100;
        txn(0, 1'b0, 1'b0, 4'b0000);

        // Wait states: 3 waits, then ack on the timeout cycle.
        m_addr_i[7:0] = 8'h44; m_we_i[0] = 1'b0; m_stb_i = 4'b0001;
        txn(3, 1'b1, 1'b0, 4'b0000);
        m_stb_i = 4'b0001;
        txn(TO - 1, 1'b1, 1'b0, 4'b0000);

        // Master 3 requests while master 0 is in ACCESS.
        m_addr_i[31:24] = 8'h55; m_data_i[31:24] = 8'h3C; m_we_i[3] = 1'b1;
        m_stb_i = 4'b0001;
        txn(1, 1'b1, 1'b0, 4'b1000);
        txn(0, 1'b1, 1'b0, 4'b0000);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            int wt;
            m_addr_i = $urandom; m_data_i = $urandom;
            m_we_i   = 4'($urandom);
            m_stb_i  = 4'($urandom_range(1, 15));
            wt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO - 2, TO + 1))
                                              : int'($urandom_range(0, 4));
            txn(wt, ($urandom_range(0, 7) != 0), 1'b0, 4'b0000);
        end

        // Asynchronous reset in the middle of ACCESS.
        m_we_i[2] = 1'b0; m_stb_i = 4'b0100; ack_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("stb_before_rst", 32'(s_stb_o), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_rst");
        m_stb_i = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_hold_ack", 32'(m_ack_o), 32'd0);
            check("rst_hold_err", 32'(m_err_o), 32'd0);
        end
        rst_n = 1'b1;
        ack_en = 1'b1;
        last_m = 3;
        exp_data = 8'h00;
        @(negedge clk);
        check("post_rst_ack", 32'(m_ack_o), 32'd0);

        // Fairness after reset: all four request continuously.
        m_we_i = 4'hF; m_data_i = $urandom; m_addr_i = $urandom;
        m_stb_i = 4'hF;
        for (int i = 0; i < 6; i++) begin
            check("fair_order", 32'(rr_model(last_m, m_stb_i)), 32'(i % 4));
            txn(0, 1'b1, 1'b1, 4'b0000);
        end
        m_stb_i = 4'b0000;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
